// File: rtl/input_capture_port_if.sv
// CPU read port of the input capture block.
//   rd_en    : read strobe, sampled every clock
//   rd_sel   : 0 = debounced switch value, 1 = event status (read-to-clear)
//   rd_data  : read data, valid while rd_valid is high, held otherwise
//   rd_valid : one-cycle pulse, one clock after an accepted rd_en
// master = CPU side, slave = input_capture_port side.
interface input_capture_port_if;
   logic        rd_en;
   logic        rd_sel;
   logic [15:0] rd_data;
   logic        rd_valid;

   modport master (
      output rd_en,
      output rd_sel,
      input  rd_data,
      input  rd_valid
   );

   modport slave (
      input  rd_en,
      input  rd_sel,
      output rd_data,
      output rd_valid
   );
endinterface

// File: rtl/input_capture_port.sv
// Input side of the board I/O. Synchronises and debounces the push-buttons
// and slide switches, latches button presses into a sticky read-to-clear
// status word and offers the CPU a one-cycle-latency read port.
//   clk       : system clock, single domain
//   rst       : synchronous, active-high reset
//   btn_in    : raw button pins (async, active-high)
//   sw_in     : raw switch pins (async)
//   bus       : CPU read port (rd_en, rd_sel, rd_data, rd_valid)
//   btn_level : debounced button levels
//   irq       : registered OR of pending press flags
// Status word: [3:0] press, [7:4] overrun, [11:8] button level, [15:12] 0.
module input_capture_port #(
   parameter int NUM_BTN         = 4,
   parameter int NUM_SW          = 16,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_BTN-1:0]   btn_in,
   input  logic [NUM_SW-1:0]    sw_in,
   input_capture_port_if.slave  bus,
   output logic [NUM_BTN-1:0]   btn_level,
   output logic                 irq
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_BTN-1:0] btn_s1, btn_s2;
   logic [NUM_SW-1:0]  sw_s1, sw_s2;

   logic [NUM_BTN-1:0] btn_stable;
   logic [CNT_W-1:0]   btn_cnt [NUM_BTN];
   logic [NUM_BTN-1:0] btn_accept;
   logic [NUM_BTN-1:0] btn_rise;

   logic [NUM_SW-1:0]  sw_stable;
   logic [CNT_W-1:0]   sw_cnt;
   logic               sw_quiet;

   logic [NUM_BTN-1:0] press, ovr;
   logic [NUM_BTN-1:0] rd_clr;
   logic [15:0]        status;

   // Two-flop synchronisers ahead of all other logic
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         btn_s1 <= btn_in;
         btn_s2 <= btn_s1;
         sw_s1  <= sw_in;
         sw_s2  <= sw_s1;
      end
   end

   // A button is accepted once it has differed from its stable level for
   // DEBOUNCE_CYCLES consecutive cycles; only 0->1 acceptances are events.
   always_comb begin
      btn_accept = '0;
      btn_rise   = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         btn_accept[i] = (btn_s2[i] != btn_stable[i]) && (btn_cnt[i] == CNT_LAST);
         btn_rise[i]   = btn_accept[i] & btn_s2[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_stable <= '0;
         for (int i = 0; i < NUM_BTN; i++) btn_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (btn_s2[i] == btn_stable[i]) begin
               btn_cnt[i] <= '0;
            end else if (btn_accept[i]) begin
               btn_stable[i] <= btn_s2[i];
               btn_cnt[i]    <= '0;
            end else begin
               btn_cnt[i] <= btn_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Switches share one counter. sw_s1 is the synced vector's next value, so
   // a mismatch with sw_s2 marks the cycle on which the synced vector changes.
   // The counter saturates at its terminal count and keeps reloading.
   assign sw_quiet = (sw_s1 == sw_s2);

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_cnt    <= '0;
         sw_stable <= '0;
      end else if (!sw_quiet) begin
         sw_cnt <= '0;
      end else if (sw_cnt == CNT_LAST) begin
         sw_stable <= sw_s2;
      end else begin
         sw_cnt <= sw_cnt + 1'b1;
      end
   end

   // Status reads clear only the flags they returned; a press arriving on
   // the clearing edge survives because the set term is ORed in last.
   assign rd_clr = (bus.rd_en && bus.rd_sel) ? press : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         press <= '0;
         ovr   <= '0;
         irq   <= 1'b0;
      end else begin
         press <= (press & ~rd_clr) | btn_rise;
         ovr   <= (ovr & ~((bus.rd_en && bus.rd_sel) ? ovr : '0)) | (btn_rise & press);
         irq   <= |press;
      end
   end

   assign status = {4'h0, 4'(btn_stable), 4'(ovr), 4'(press)};

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rd_data  <= '0;
         bus.rd_valid <= 1'b0;
      end else begin
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en) begin
            bus.rd_data <= bus.rd_sel ? status : 16'(sw_stable);
         end
      end
   end

   assign btn_level = btn_stable;

endmodule

// File: tb/tb_input_capture_port.sv
module tb_input_capture_port;
   localparam int NUM_BTN = 4;
   localparam int NUM_SW  = 16;
   localparam int DEB     = 4;
   localparam int CNT_W   = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  btn_in;
   logic [15:0] sw_in;
   logic [3:0]  btn_level;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

   input_capture_port_if bus();

   input_capture_port #(
      .NUM_BTN(NUM_BTN), .NUM_SW(NUM_SW), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .sw_in(sw_in),
      .bus(bus), .btn_level(btn_level), .irq(irq)
   );

   always #5 clk = ~clk;

   // Behavioural reference: keeps a short history of pin samples per edge and
   // applies the debounce rules as window conditions on that history.
   logic [3:0]  m_stable, m_press, m_ovr;
   logic [15:0] m_sw, m_rd_data;
   logic        m_rd_valid, m_irq;
   logic [3:0]  bq[$];
   logic [15:0] sq[$];

   task automatic model_edge();
      logic [3:0] rise, nst, np, no;
      logic       all_diff, eq, rdclr;
      int         s;
      if (rst) begin
         m_stable = '0; m_press = '0; m_ovr = '0; m_sw = '0;
         m_rd_data = '0; m_rd_valid = 1'b0; m_irq = 1'b0;
         bq.delete(); sq.delete();
         for (int k = 0; k < 5; k++) begin
            bq.push_back(4'h0);
            sq.push_back(16'h0);
         end
         return;
      end
      rise = '0;
      nst  = m_stable;
      s    = bq.size();
      for (int i = 0; i < 4; i++) begin
         all_diff = 1'b1;
         for (int j = s - 5; j <= s - 2; j++)
            if (bq[j][i] == m_stable[i]) all_diff = 1'b0;
         if (all_diff) begin
            nst[i]  = ~m_stable[i];
            rise[i] = nst[i];
         end
      end
      rdclr = bus.rd_en & bus.rd_sel;
      if (bus.rd_en) begin
         m_rd_valid = 1'b1;
         m_rd_data  = bus.rd_sel ? {4'h0, m_stable, m_ovr, m_press} : m_sw;
      end else begin
         m_rd_valid = 1'b0;
      end
      m_irq = |m_press;
      no = rdclr ? (rise & m_press) : (m_ovr | (rise & m_press));
      np = rdclr ? rise : (m_press | rise);
      eq = 1'b1;
      s  = sq.size();
      for (int j = s - 5; j <= s - 1; j++)
         if (sq[j] != sq[s-1]) eq = 1'b0;
      if (eq) m_sw = sq[s-1];
      m_stable = nst; m_press = np; m_ovr = no;
      bq.push_back(btn_in);
      sq.push_back(sw_in);
      while (bq.size() > 8) void'(bq.pop_front());
      while (sq.size() > 8) void'(sq.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1; btn_in = '0; sw_in = '0; bus.rd_en = 1'b0; bus.rd_sel = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic do_read(input logic sel, output logic [15:0] d, output logic v);
      bus.rd_en = 1'b1; bus.rd_sel = sel;
      tick();
      d = bus.rd_data; v = bus.rd_valid;
      bus.rd_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] d; logic v;
      rst = 1'b1; btn_in = '0; sw_in = '0; bus.rd_en = 1'b0; bus.rd_sel = 1'b0;
      tick(); tick();
      n_vec++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
      n_vec++; if (bus.rd_data !== 16'h0) begin n_err++; $display("FAIL reset_rd_data got %h want 0000", bus.rd_data); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
      n_vec++; if (btn_level !== 4'h0) begin n_err++; $display("FAIL reset_btn_level got %h want 0", btn_level); end
      rst = 1'b0;
      do_read(1'b1, d, v);
      n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL reset_read_valid got %b want 1", v); end
      n_vec++; if (d !== 16'h0000) begin n_err++; $display("FAIL reset_status got %h want 0000", d); end
   endtask

   task automatic test_btn_press();
      logic [15:0] d; logic v;
      apply_reset();
      btn_in = 4'b0001;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 5) begin
            n_vec++; if (btn_level[0] !== 1'b0) begin n_err++; $display("FAIL press_level_c5 got %b want 0", btn_level[0]); end
         end
      end
      n_vec++; if (btn_level[0] !== 1'b1) begin n_err++; $display("FAIL press_level_c6 got %b want 1", btn_level[0]); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL press_irq_c6 got %b want 0", irq); end
      tick();
      n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL press_irq_c7 got %b want 1", irq); end
      do_read(1'b1, d, v);
      n_vec++; if (v !== 1'b1 || d !== 16'h0101) begin n_err++; $display("FAIL press_status got %h/%b want 0101/1", d, v); end
      tick();
      n_vec++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0101) begin
         n_err++; $display("FAIL press_hold got %h/%b want 0101/0", bus.rd_data, bus.rd_valid); end
      do_read(1'b1, d, v);
      n_vec++; if (d !== 16'h0100) begin n_err++; $display("FAIL press_reread got %h want 0100", d); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL press_irq_clear got %b want 0", irq); end
      btn_in = '0;
   endtask

   task automatic test_bounce();
      logic [15:0] d; logic v;
      apply_reset();
      btn_in = 4'b0010;
      tick(); tick(); tick();
      btn_in = '0;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_vec++; if (btn_level !== 4'h0 || irq !== 1'b0) begin
            n_err++; $display("FAIL bounce_level_irq got %h/%b want 0/0", btn_level, irq); end
      end
      do_read(1'b1, d, v);
      n_vec++; if (d !== 16'h0000) begin n_err++; $display("FAIL bounce_status got %h want 0000", d); end
   endtask

   task automatic test_double_press();
      logic [15:0] d; logic v;
      apply_reset();
      for (int p = 0; p < 2; p++) begin
         btn_in = 4'b0100; repeat (8) tick();
         btn_in = 4'b0000; repeat (8) tick();
      end
      n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL double_irq got %b want 1", irq); end
      do_read(1'b1, d, v);
      n_vec++; if (d !== 16'h0044) begin n_err++; $display("FAIL double_status got %h want 0044", d); end
      tick();
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL double_irq_clear got %b want 0", irq); end
      do_read(1'b1, d, v);
      n_vec++; if (d !== 16'h0000) begin n_err++; $display("FAIL double_reread got %h want 0000", d); end
   endtask

   task automatic test_simultaneous();
      logic [15:0] d; logic v;
      apply_reset();
      btn_in = 4'b0110;
      repeat (6) tick();
      n_vec++; if (btn_level !== 4'b0110) begin n_err++; $display("FAIL simul_level got %h want 6", btn_level); end
      tick();
      do_read(1'b1, d, v);
      n_vec++; if (d !== 16'h0606) begin n_err++; $display("FAIL simul_status got %h want 0606", d); end
      btn_in = '0;
   endtask

   task automatic test_switch();
      logic [15:0] d; logic v; logic seen_new;
      apply_reset();
      sw_in = 16'hA5C3;
      repeat (10) tick();
      do_read(1'b0, d, v);
      n_vec++; if (d !== 16'hA5C3) begin n_err++; $display("FAIL sw_initial got %h want a5c3", d); end
      bus.rd_en = 1'b1; bus.rd_sel = 1'b0;
      for (int t = 0; t < 7; t++) begin
         sw_in[0] = ~sw_in[0];
         for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (bus.rd_data !== 16'hA5C3) begin n_err++; $display("FAIL sw_toggling got %h want a5c3", bus.rd_data); end
         end
      end
      seen_new = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         n_vec++; if (bus.rd_data !== m_rd_data) begin
            n_err++; $display("FAIL sw_settle cycle %0d got %h want %h", c, bus.rd_data, m_rd_data); end
         if (bus.rd_data === 16'hA5C2) seen_new = 1'b1;
         if (c == 0) begin
            n_vec++; if (bus.rd_data !== 16'hA5C3) begin n_err++; $display("FAIL sw_early got %h want a5c3", bus.rd_data); end
         end
      end
      bus.rd_en = 1'b0;
      n_vec++; if (!seen_new || bus.rd_data !== 16'hA5C2) begin
         n_err++; $display("FAIL sw_final got %h want a5c2", bus.rd_data); end
   endtask

   task automatic test_set_wins();
      logic [15:0] d; logic v;
      apply_reset();
      btn_in = 4'b1000; repeat (8) tick();
      btn_in = 4'b0000; repeat (8) tick();
      btn_in = 4'b1000;
      repeat (5) tick();
      bus.rd_en = 1'b1; bus.rd_sel = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      n_vec++; if (bus.rd_data !== 16'h0008 || btn_level[3] !== 1'b1) begin
         n_err++; $display("FAIL setwin_first got %h lvl %b want 0008 lvl 1", bus.rd_data, btn_level[3]); end
      do_read(1'b1, d, v);
      n_vec++; if (d[3] !== 1'b1) begin n_err++; $display("FAIL setwin_press3 got %b want 1", d[3]); end
      n_vec++; if (d !== 16'h0888) begin n_err++; $display("FAIL setwin_status got %h want 0888", d); end
      btn_in = '0;
   endtask

   task automatic test_reset_mid();
      logic [15:0] d; logic v;
      apply_reset();
      btn_in = 4'b0001;
      repeat (3) tick();
      rst = 1'b1; tick(); tick();
      n_vec++; if (btn_level !== 4'h0) begin n_err++; $display("FAIL midrst_level got %h want 0", btn_level); end
      rst = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 5) begin
            n_vec++; if (btn_level[0] !== 1'b0) begin n_err++; $display("FAIL midrst_early got %b want 0", btn_level[0]); end
         end
      end
      n_vec++; if (btn_level[0] !== 1'b1) begin n_err++; $display("FAIL midrst_level6 got %b want 1", btn_level[0]); end
      tick();
      do_read(1'b1, d, v);
      n_vec++; if (d !== 16'h0101) begin n_err++; $display("FAIL midrst_status got %h want 0101", d); end
      btn_in = '0;
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 5) == 0) btn_in[i] = ~btn_in[i];
         if ($urandom_range(0, 15) == 0) sw_in = 16'($urandom);
         else if ($urandom_range(0, 9) == 0) sw_in[$urandom_range(0, 15)] ^= 1'b1;
         bus.rd_en  = ($urandom_range(0, 2) == 0);
         bus.rd_sel = 1'($urandom_range(0, 1));
         tick();
         n_vec++; if (btn_level !== m_stable) begin
            n_err++; $display("FAIL rnd_level cycle %0d got %h want %h", c, btn_level, m_stable); end
         n_vec++; if (irq !== m_irq) begin
            n_err++; $display("FAIL rnd_irq cycle %0d got %b want %b", c, irq, m_irq); end
         n_vec++; if (bus.rd_valid !== m_rd_valid) begin
            n_err++; $display("FAIL rnd_valid cycle %0d got %b want %b", c, bus.rd_valid, m_rd_valid); end
         n_vec++; if (bus.rd_data !== m_rd_data) begin
            n_err++; $display("FAIL rnd_data cycle %0d got %h want %h", c, bus.rd_data, m_rd_data); end
      end
      bus.rd_en = 1'b0;
      btn_in = '0;
   endtask

   initial begin
      rst = 1'b1; btn_in = '0; sw_in = '0; bus.rd_en = 1'b0; bus.rd_sel = 1'b0;
      test_reset();
      test_btn_press();
      test_bounce();
      test_double_press();
      test_simultaneous();
      test_switch();
      test_set_wins();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
